word_enum_driver: RTL and testbench
===================================

Name: word_enum_driver

Overview:
- Stimulus-side counterpart to the automaton equivalence miter. It drives input words into a pair of single-bit-input automata and compares their accept outputs.
- Enumerates every binary word of length 0..MAX_LEN in shortlex order. For each word it pulses the automata reset, serially feeds the symbols, then samples both accept outputs.
- Stops on the first disagreement and latches the counterexample, or finishes with found=0 after the whole space is exhausted.
- Sits beside two automaton instances in bounded-equivalence benches and FPGA self-checks.

Parameters:
- MAX_LEN, 8, longest word length enumerated (legal range 1..16).
- LEN_W, $clog2(MAX_LEN+1), width of length fields (derived; not overridden).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins enumeration when idle.
- acc_a  input  1  accept output of automaton A.
- acc_b  input  1  accept output of automaton B.
- dut_reset  output  1  reset to both automata.
- dut_in  output  1  current input symbol to both automata.
- dut_valid  output  1  high while dut_in carries a symbol.
- busy  output  1  enumeration in progress.
- done  output  1  enumeration finished (sticky until next start or reset).
- found  output  1  mismatch detected (valid when done=1).
- cex_word  output  MAX_LEN  counterexample symbols; bit 0 = first symbol fed.
- cex_len  output  LEN_W  counterexample length.
- words_tested  output  MAX_LEN+1  words checked, including the failing word.

Behaviour:
- Only one clock and one reset are used. Reset is synchronous and active-high; the ports are named clk and reset.
- Reset (any state, including mid-word): state=IDLE. All outputs are 0, including cex_word, cex_len and words_tested.
- Internal registers: word[MAX_LEN-1:0], len[LEN_W-1:0], idx[LEN_W-1:0].
- IDLE: outputs idle.
  - start=1 -> clear done, found, cex_* and words_tested; set word=0, len=0; go to RST.
- RST (1 cycle): dut_reset=1, dut_valid=0.
  - len==0 -> CHECK; else idx=0 -> FEED.
- FEED (len cycles): dut_reset=0, dut_valid=1, dut_in=word[idx], idx++.
  - After idx==len-1 -> CHECK.
- CHECK (1 cycle): dut_valid=0, dut_reset=0, dut_in=0. acc_a and acc_b are sampled this cycle; they reflect the automata state after all symbols were consumed. words_tested++.
  - acc_a!=acc_b: cex_word=word with bits >= len forced to 0; cex_len=len; found=1 -> FIN.
  - Else if word==2^len-1:
    - len==MAX_LEN -> FIN with found=0.
    - Otherwise len++, word=0 -> RST.
  - Else word++ -> RST.
- FIN: done=1 and busy=0, both held. start=1 restarts exactly as from IDLE.
- busy=1 in RST, FEED and CHECK.
- start is ignored while busy.
- Cost per word of length L is L+2 cycles. Full run costs sum over L of 2^L*(L+2) cycles.
- done rises in the cycle after the final CHECK.
- words_tested never wraps: its maximum is 2^(MAX_LEN+1)-1.
- The len==0 word makes no FEED cycle; the initial-state verdict is compared directly.

Test Plan:
- MAX_LEN=3, A and B both the "last symbol is 1" automaton, start pulse -> done=1 and found=0 exactly 64 cycles after the first RST cycle; words_tested=15; dut_valid high for 34 cycles total.
- MAX_LEN=3, A = "last symbol 1", B = "contains a 1" -> found=1, cex_len=2, cex_word=2'b01 (symbols 1 then 0), words_tested=5.
- acc_a tied 0, acc_b tied 1 -> found=1, cex_len=0, cex_word=0, words_tested=1; done high 2 cycles after start.
- Waveform check, MAX_LEN=2: symbol order per word is bit 0 first; dut_reset is high exactly one cycle before every word; the sequence of (len, word) pairs is (0,0),(1,0),(1,1),(2,0),(2,1),(2,2),(2,3).
- Reset asserted during FEED of a length-3 word -> next cycle IDLE, all outputs 0; a later start restarts from the empty word with words_tested=0.
- start pulsed during RST/FEED -> no effect on sequence; start pulsed in FIN -> outputs clear and the run repeats with identical results.

Source files
------------

// File: rtl/word_enum_driver.sv
// word_enum_driver: feeds every binary word of length 0..MAX_LEN (shortlex order)
// to two automata and latches the first word on which their accept outputs differ.
module word_enum_driver #(
    parameter int MAX_LEN = 8,
    localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               acc_a,
    input  logic               acc_b,
    output logic               dut_reset,
    output logic               dut_in,
    output logic               dut_valid,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [MAX_LEN-1:0] cex_word,
    output logic [LEN_W-1:0]   cex_len,
    output logic [MAX_LEN:0]   words_tested
);
    typedef enum logic [2:0] {IDLE, RST, FEED, CHECK, FIN} state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] word_q, word_d, cex_word_q, cex_word_d, sh;
    logic [LEN_W-1:0]   len_q, len_d, idx_q, idx_d, cex_len_q, cex_len_d;
    logic [MAX_LEN:0]   cnt_q, cnt_d, full;
    logic               found_q, found_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            word_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            cex_word_q <= '0;
            cex_len_q  <= '0;
            cnt_q      <= '0;
            found_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            cex_word_q <= cex_word_d;
            cex_len_q  <= cex_len_d;
            cnt_q      <= cnt_d;
            found_q    <= found_d;
        end
    end

    // full = 2^len - 1, one bit wider than word so len==MAX_LEN does not overflow
    assign full = ({{MAX_LEN{1'b0}}, 1'b1} << len_q) - 1'b1;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        len_d      = len_q;
        idx_d      = idx_q;
        cex_word_d = cex_word_q;
        cex_len_d  = cex_len_q;
        cnt_d      = cnt_q;
        found_d    = found_q;
        case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    state_d    = RST;
                    word_d     = '0;
                    len_d      = '0;
                    cex_word_d = '0;
                    cex_len_d  = '0;
                    cnt_d      = '0;
                    found_d    = 1'b0;
                end
            end
            RST: begin
                idx_d   = '0;
                state_d = (len_q == '0) ? CHECK : FEED;
            end
            FEED: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == len_q - 1'b1) state_d = CHECK;
            end
            CHECK: begin
                cnt_d = cnt_q + 1'b1;
                if (acc_a != acc_b) begin
                    cex_word_d = word_q & full[MAX_LEN-1:0];
                    cex_len_d  = len_q;
                    found_d    = 1'b1;
                    state_d    = FIN;
                end else if ({1'b0, word_q} == full) begin
                    if (len_q == LEN_W'(MAX_LEN)) begin
                        state_d = FIN;
                    end else begin
                        len_d   = len_q + 1'b1;
                        word_d  = '0;
                        state_d = RST;
                    end
                end else begin
                    word_d  = word_q + 1'b1;
                    state_d = RST;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sh           = word_q >> idx_q;
        dut_reset    = (state_q == RST);
        dut_valid    = (state_q == FEED);
        dut_in       = (state_q == FEED) ? sh[0] : 1'b0;
        busy         = (state_q == RST) || (state_q == FEED) || (state_q == CHECK);
        done         = (state_q == FIN);
        found        = found_q;
        cex_word     = cex_word_q;
        cex_len      = cex_len_q;
        words_tested = cnt_q;
    end
endmodule

// File: tb/tb_word_enum_driver.sv
// tb_word_enum_driver: directed checks of word_enum_driver (MAX_LEN=3) against
// small behavioural automata models driven by the DUT's own reset/symbol outputs.
module tb_word_enum_driver;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       acc_a, acc_b;
    logic       dut_reset, dut_in, dut_valid, busy, done, found;
    logic [2:0] cex_word;
    logic [1:0] cex_len;
    logic [3:0] words_tested;

    int tests = 0;
    int fails = 0;
    int mode = 0;
    int got_len[$];
    int got_word[$];
    logic last1 = 1'b0;
    logic has1 = 1'b0;

    word_enum_driver #(.MAX_LEN(3)) dut (
        .clk(clk), .reset(reset), .start(start), .acc_a(acc_a), .acc_b(acc_b),
        .dut_reset(dut_reset), .dut_in(dut_in), .dut_valid(dut_valid),
        .busy(busy), .done(done), .found(found), .cex_word(cex_word),
        .cex_len(cex_len), .words_tested(words_tested)
    );

    always #5 clk = ~clk;

    // mode 0: both "last symbol is 1"; mode 1: B is "contains a 1"; mode 2: A=0, B=1
    always @(posedge clk) begin
        if (dut_reset) begin
            last1 <= 1'b0;
            has1  <= 1'b0;
        end else if (dut_valid) begin
            last1 <= dut_in;
            has1  <= has1 | dut_in;
        end
    end
    assign acc_a = (mode == 2) ? 1'b0 : last1;
    assign acc_b = (mode == 0) ? last1 : (mode == 1) ? has1 : 1'b1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_capture(input bit noisy, output int cyc, output int nval, output int nrst);
        int l;
        logic [2:0] w;
        got_len.delete();
        got_word.delete();
        cyc = 0; nval = 0; nrst = 0; l = 0; w = '0;
        while (!done && cyc < 1000) begin
            if (dut_reset) begin
                nrst++;
                l = 0;
                w = '0;
            end
            if (dut_valid) begin
                nval++;
                w = w | (3'(dut_in) << l);
                l++;
            end
            if (busy && !dut_reset && !dut_valid) begin
                got_len.push_back(l);
                got_word.push_back(int'(w));
            end
            start = noisy && (cyc % 7 == 3);
            tick();
            cyc++;
        end
        start = 1'b0;
        tests++;
        if (cyc >= 1000) begin
            fails++;
            $display("FAIL run_timeout: done never rose within %0d cycles", cyc);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tests++;
        if ({busy, done, found, dut_reset, dut_valid, dut_in} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 000000", {busy, done, found, dut_reset, dut_valid, dut_in});
        end
        tests++;
        if ({cex_word, cex_len, words_tested} !== 9'b0) begin
            fails++;
            $display("FAIL reset_data: got %h want 000", {cex_word, cex_len, words_tested});
        end
    endtask

    task automatic check_full_pass(input string tag, input int cyc, input int nval, input int nrst);
    endtask

    task automatic test_enum_equal;
        int cyc, nval, nrst, k;
        mode = 0;
        pulse_start();
        tests++;
        if (dut_reset !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL eq_first_rst: dut_reset=%b busy=%b want 1 1", dut_reset, busy);
        end
        run_capture(1'b0, cyc, nval, nrst);
        tests++;
        if (cyc != 64) begin fails++; $display("FAIL eq_cycles: got %0d want 64", cyc); end
        tests++;
        if (found !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL eq_found: found=%b busy=%b want 0 0", found, busy);
        end
        tests++;
        if (words_tested !== 4'd15) begin fails++; $display("FAIL eq_words: got %0d want 15", words_tested); end
        tests++;
        if (nval != 34) begin fails++; $display("FAIL eq_valid_cycles: got %0d want 34", nval); end
        tests++;
        if (nrst != 15) begin fails++; $display("FAIL eq_reset_pulses: got %0d want 15", nrst); end
        tests++;
        if (got_len.size() != 15) begin
            fails++;
            $display("FAIL eq_seq_size: got %0d want 15", got_len.size());
        end else begin
            k = 0;
            for (int len = 0; len <= 3; len++)
                for (int w = 0; w < (1 << len); w++) begin
                    tests++;
                    if (got_len[k] != len || got_word[k] != w) begin
                        fails++;
                        $display("FAIL eq_seq[%0d]: got (%0d,%0d) want (%0d,%0d)", k, got_len[k], got_word[k], len, w);
                    end
                    k++;
                end
        end
    endtask

    task automatic test_restart_mismatch;
        int cyc, nval, nrst;
        mode = 1;
        pulse_start();
        tests++;
        if (done !== 1'b0 || found !== 1'b0 || words_tested !== 4'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL restart_clear: done=%b found=%b words=%0d busy=%b want 0 0 0 1", done, found, words_tested, busy);
        end
        run_capture(1'b0, cyc, nval, nrst);
        tests++;
        if (cyc != 16) begin fails++; $display("FAIL mm_cycles: got %0d want 16", cyc); end
        tests++;
        if (found !== 1'b1) begin fails++; $display("FAIL mm_found: got %b want 1", found); end
        tests++;
        if (cex_len !== 2'd2 || cex_word !== 3'b001) begin
            fails++;
            $display("FAIL mm_cex: got len=%0d word=%b want len=2 word=001", cex_len, cex_word);
        end
        tests++;
        if (words_tested !== 4'd5) begin fails++; $display("FAIL mm_words: got %0d want 5", words_tested); end
    endtask

    task automatic test_immediate;
        int cyc, nval, nrst;
        mode = 2;
        pulse_start();
        run_capture(1'b0, cyc, nval, nrst);
        tests++;
        if (cyc != 2) begin fails++; $display("FAIL imm_cycles: got %0d want 2", cyc); end
        tests++;
        if (found !== 1'b1 || cex_len !== 2'd0 || cex_word !== 3'd0 || words_tested !== 4'd1) begin
            fails++;
            $display("FAIL imm_result: found=%b len=%0d word=%b words=%0d want 1 0 000 1", found, cex_len, cex_word, words_tested);
        end
        tests++;
        if (nval != 0) begin fails++; $display("FAIL imm_valid: got %0d want 0", nval); end
    endtask

    task automatic test_reset_mid_feed;
        int cyc, nval, nrst;
        mode = 0;
        pulse_start();
        // first length-3 word: RST at cycle 24, FEED at 25..27
        for (int i = 0; i < 26; i++) tick();
        tests++;
        if (dut_valid !== 1'b1) begin fails++; $display("FAIL mid_in_feed: dut_valid=%b want 1", dut_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if ({busy, done, found, dut_reset, dut_valid, dut_in, cex_word, cex_len, words_tested} !== 15'b0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got %h want 0000", {busy, done, found, dut_reset, dut_valid, dut_in, cex_word, cex_len, words_tested});
        end
        tick();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL mid_stays_idle: busy=%b want 0", busy); end
        pulse_start();
        tests++;
        if (words_tested !== 4'd0 || dut_reset !== 1'b1) begin
            fails++;
            $display("FAIL mid_restart: words=%0d dut_reset=%b want 0 1", words_tested, dut_reset);
        end
        run_capture(1'b0, cyc, nval, nrst);
        tests++;
        if (cyc != 64 || found !== 1'b0 || words_tested !== 4'd15) begin
            fails++;
            $display("FAIL mid_rerun: cycles=%0d found=%b words=%0d want 64 0 15", cyc, found, words_tested);
        end
        tests++;
        if (got_len.size() < 1 || got_len[0] != 0) begin
            fails++;
            $display("FAIL mid_first_word: size=%0d want first word empty", got_len.size());
        end
    endtask

    task automatic test_start_while_busy;
        int cyc, nval, nrst, k;
        mode = 0;
        pulse_start();
        run_capture(1'b1, cyc, nval, nrst);
        tests++;
        if (cyc != 64 || nval != 34 || nrst != 15) begin
            fails++;
            $display("FAIL busy_start_timing: cycles=%0d valid=%0d resets=%0d want 64 34 15", cyc, nval, nrst);
        end
        tests++;
        if (found !== 1'b0 || words_tested !== 4'd15 || done !== 1'b1) begin
            fails++;
            $display("FAIL busy_start_result: found=%b words=%0d done=%b want 0 15 1", found, words_tested, done);
        end
        tests++;
        if (got_len.size() != 15) begin
            fails++;
            $display("FAIL busy_seq_size: got %0d want 15", got_len.size());
        end else begin
            k = 0;
            for (int len = 0; len <= 3; len++)
                for (int w = 0; w < (1 << len); w++) begin
                    if (got_len[k] != len || got_word[k] != w) begin
                        fails++;
                        $display("FAIL busy_seq[%0d]: got (%0d,%0d) want (%0d,%0d)", k, got_len[k], got_word[k], len, w);
                    end
                    k++;
                end
        end
    endtask

    task automatic test_done_sticky;
        for (int i = 0; i < 5; i++) tick();
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || words_tested !== 4'd15) begin
            fails++;
            $display("FAIL done_sticky: done=%b busy=%b words=%0d want 1 0 15", done, busy, words_tested);
        end
    endtask

    initial begin
        test_reset();
        test_enum_equal();
        test_restart_mismatch();
        test_immediate();
        test_reset_mid_feed();
        test_start_while_busy();
        test_done_sticky();
        test_restart_mismatch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
